// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Run control, program counter and cycle/instruction counters
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter int unsigned        PW         = 10,
  parameter int unsigned        CW         = 16,
  parameter logic [PW-1:0]      START_ADDR = '0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Halt,
  input  logic          BranchEn,
  input  logic          BranchRel,
  input  logic [PW-1:0] Target,
  input  logic          Stall,
  output logic [PW-1:0] PgmCtr,
  output logic          Running,
  output logic          Ack,
  output logic [CW-1:0] CycleCt,
  output logic [CW-1:0] InstCt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_pgmCtr;
  logic          r_ack;
  logic [CW-1:0] r_cycleCt;
  logic [CW-1:0] r_instCt;

  logic [CW-1:0] w_cycleInc;
  logic [CW-1:0] w_instInc;
  logic [PW-1:0] w_nextPc;

  // Counters stick at all-ones rather than wrapping.
  assign w_cycleInc = (r_cycleCt == '1) ? r_cycleCt : r_cycleCt + CW'(1);
  assign w_instInc  = (r_instCt  == '1) ? r_instCt  : r_instCt  + CW'(1);

  // PW-bit addition gives modulo-2**PW wrap for both signed offsets and +1.
  always_comb begin
    w_nextPc = r_pgmCtr + PW'(1);
    if (BranchEn) begin
      if (BranchRel) w_nextPc = r_pgmCtr + Target;
      else           w_nextPc = Target;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_pgmCtr  <= START_ADDR;
      r_ack     <= 1'b0;
      r_cycleCt <= '0;
      r_instCt  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            r_state   <= S_ARM;
            r_pgmCtr  <= START_ADDR;
            r_ack     <= 1'b0;
            r_cycleCt <= '0;
            r_instCt  <= '0;
          end
        end
        S_ARM: begin
          if (!Start) r_state <= S_RUN;
        end
        S_RUN: begin
          // A fresh Start aborts the program ahead of anything the decoder asks.
          if (Start) begin
            r_state   <= S_ARM;
            r_pgmCtr  <= START_ADDR;
            r_ack     <= 1'b0;
            r_cycleCt <= '0;
            r_instCt  <= '0;
          end else begin
            r_cycleCt <= w_cycleInc;
            if (Halt) begin
              r_state  <= S_DONE;
              r_ack    <= 1'b1;
              r_instCt <= w_instInc;
            end else if (!Stall) begin
              r_pgmCtr <= w_nextPc;
              r_instCt <= w_instInc;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign PgmCtr  = r_pgmCtr;
  assign Ack     = r_ack;
  assign CycleCt = r_cycleCt;
  assign InstCt  = r_instCt;
  assign Running = (r_state == S_RUN);

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Directed and random checks of fetch_sequencer against a model
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  localparam int PW = 4;
  localparam int CW = 4;
  localparam int PC_MOD  = 1 << PW;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Reset, Start, Halt, BranchEn, BranchRel, Stall;
  logic [PW-1:0] Target;
  logic [PW-1:0] PgmCtr;
  logic          Running, Ack;
  logic [CW-1:0] CycleCt, InstCt;

  fetch_sequencer #(.PW(PW), .CW(CW), .START_ADDR(4'd0)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
    .BranchEn(BranchEn), .BranchRel(BranchRel), .Target(Target),
    .Stall(Stall), .PgmCtr(PgmCtr), .Running(Running), .Ack(Ack),
    .CycleCt(CycleCt), .InstCt(InstCt)
  );

  always #5 Clk = ~Clk;

  int assertCt = 0;
  int failCt   = 0;

  // Reference model: phase is a plain label for where the program is.
  string mPhase = "idle";
  int    mPc = 0, mCyc = 0, mInst = 0;
  bit    mAck = 0;

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCt++;
    assert (obs === exp) else begin
      failCt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rs, st, hl, be, rl, input int tg, input bit sl);
    int off;
    if (rs) begin
      mPhase = "idle"; mPc = 0; mAck = 0; mCyc = 0; mInst = 0;
    end else if (st && mPhase != "armed") begin
      mPhase = "armed"; mPc = 0; mAck = 0; mCyc = 0; mInst = 0;
    end else if (mPhase == "armed") begin
      if (!st) mPhase = "run";
    end else if (mPhase == "run") begin
      mCyc = sat(mCyc + 1);
      if (hl) begin
        mPhase = "done"; mAck = 1; mInst = sat(mInst + 1);
      end else if (!sl) begin
        mInst = sat(mInst + 1);
        off = (tg >= PC_MOD / 2) ? tg - PC_MOD : tg;
        if (!be)     mPc = (mPc + 1) % PC_MOD;
        else if (rl) mPc = ((mPc + off) % PC_MOD + PC_MOD) % PC_MOD;
        else         mPc = tg;
      end
    end
  endtask

  task automatic step(input bit rs, st, hl, be, rl, input int tg, input bit sl);
    Reset = rs; Start = st; Halt = hl; BranchEn = be; BranchRel = rl;
    Target = tg[PW-1:0]; Stall = sl;
    model(rs, st, hl, be, rl, tg, sl);
    @(posedge Clk);
    #1;
    check("PgmCtr",  32'(PgmCtr),  32'(mPc));
    check("Ack",     32'(Ack),     32'(mAck));
    check("CycleCt", 32'(CycleCt), 32'(mCyc));
    check("InstCt",  32'(InstCt),  32'(mInst));
    check("Running", 32'(Running), 32'(mPhase == "run"));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic launch();
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("reset_pc", 32'(PgmCtr), 32'd0);

    // Two-cycle Start pulse, five sequential fetches, then Halt at PC=5
    step(0, 1, 1, 1, 0, 9, 1);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    idle(5);
    step(0, 0, 1, 0, 0, 0, 0);
    check("halt_pc",   32'(PgmCtr),  32'd5);
    check("halt_inst", 32'(InstCt),  32'd6);
    check("halt_cyc",  32'(CycleCt), 32'd6);
    check("halt_ack",  32'(Ack),     32'd1);
    step(0, 0, 0, 1, 0, 3, 0);
    check("done_hold", 32'(PgmCtr), 32'd5);

    // Straight run of 17 cycles: PC wraps, counters saturate, no Ack
    launch();
    idle(17);
    check("wrap_pc",  32'(PgmCtr),  32'd1);
    check("sat_cyc",  32'(CycleCt), 32'd15);
    check("wrap_ack", 32'(Ack),     32'd0);

    // Absolute and relative branches, including negative wrap below 0
    launch();
    idle(8);
    step(0, 0, 0, 1, 0, 3, 0);
    check("abs_br", 32'(PgmCtr), 32'd3);
    step(0, 0, 0, 1, 1, 14, 0);
    check("rel_m2", 32'(PgmCtr), 32'd1);
    step(0, 0, 0, 1, 1, 15, 0);
    step(0, 0, 0, 1, 1, 15, 0);
    check("rel_wrap", 32'(PgmCtr), 32'd15);

    // Stall beats BranchEn for three cycles at PC=5
    launch();
    step(0, 0, 0, 1, 0, 5, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 12, 1);
    check("stall_pc",   32'(PgmCtr), 32'd5);
    check("stall_inst", 32'(InstCt), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    check("stall_release", 32'(PgmCtr), 32'd6);

    // Halt together with Stall at PC=7, then Start aborts a running program
    step(0, 0, 0, 1, 0, 7, 0);
    step(0, 0, 1, 0, 0, 0, 1);
    check("hs_pc", 32'(PgmCtr), 32'd7);
    launch();
    idle(3);
    step(0, 1, 1, 1, 0, 9, 0);
    check("abort_pc",  32'(PgmCtr),  32'd0);
    check("abort_cyc", 32'(CycleCt), 32'd0);

    // Reset in the same cycle as Halt
    step(0, 0, 0, 0, 0, 0, 0);
    idle(2);
    step(1, 0, 1, 0, 0, 0, 0);
    check("rst_halt_ack", 32'(Ack), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(63) == 0, $urandom_range(15) == 0,
           $urandom_range(15) == 0, $urandom_range(3) == 0,
           $urandom_range(1) == 1, int'($urandom_range(PC_MOD - 1)),
           $urandom_range(3) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCt, failCt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Parametrised run-control and program-counter block for the 3BC processor family. It replaces the fixed 10-bit program counter and its separate enable logic with a single sequencer that owns the Start/Ack program handshake, sequential fetch, absolute and PC-relative branching, single-cycle stalls for multicycle data-memory operations, and saturating cycle and instruction counters. It sits between the top level (Start/Ack) and the instruction ROM address, and takes Halt, BranchEn and Stall from the control decoder.

## Interface
- PW, 10: program counter width; the instruction ROM depth is 2**PW.
- CW, 16: width of the cycle and instruction counters.
- START_ADDR, 0: PC value loaded on reset and on every program arm (PW bits).
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high; highest priority.
- Start  in  1  level request. High arms a new program; the program runs after Start falls.
- Halt  in  1  current instruction is the done/halt opcode.
- BranchEn  in  1  take the branch this cycle.
- BranchRel  in  1  0 = absolute Target; 1 = Target is a signed PC-relative offset.
- Target  in  PW  branch address or two's-complement offset.
- Stall  in  1  hold PC this cycle (instruction not yet retired).
- PgmCtr  out  PW  instruction ROM address.
- Running  out  1  high while in RUN (combinational decode of state).
- Ack  out  1  registered done flag.
- CycleCt  out  CW  cycles spent in RUN.
- InstCt  out  CW  instructions retired.

## Operation
- States: IDLE, ARM, RUN, DONE.
- Reset: state=IDLE, PgmCtr=START_ADDR, Ack=0, CycleCt=0, InstCt=0, Running=0.
- IDLE or DONE, Start=1: go to ARM, load PgmCtr=START_ADDR, clear both counters, set Ack=0.
- ARM, Start=1: stay; PC and counters are held at their cleared values. ARM, Start=0: go to RUN.
- RUN, Start=1: abort to ARM with the same loads as above; this has priority over Halt, Stall and branch.
- RUN priority per cycle, highest first:
  - Halt: go to DONE, set Ack=1, hold PC, InstCt+1.
  - Stall: hold PC; InstCt unchanged.
  - BranchEn with BranchRel=0: PgmCtr=Target.
  - BranchEn with BranchRel=1: PgmCtr=PgmCtr+Target, with Target read as signed PW bits.
  - Otherwise: PgmCtr+1.
  - InstCt+1 on every non-stalled cycle, including a branch.
- CycleCt+1 on every RUN cycle, including the Halt cycle and stalled cycles.
- PC arithmetic is modulo 2**PW: wraps from all-ones to 0, and a relative branch below 0 wraps.
- Counters saturate at 2**CW-1 and do not wrap.
- DONE: PC, counters and Ack=1 are held until Start or Reset. Halt, BranchEn and Stall are ignored outside RUN.

## Timing
- All outputs except Running are registered. Running changes on the same edge as the state.
- Start falls in cycle n (ARM) -> RUN from edge n+1. The first fetch is at START_ADDR during cycle n+1.
- Branch/sequential latency: the new PgmCtr is visible one cycle after the decision cycle. There are no delay slots.
- Ack rises on the edge that ends the Halt cycle. Ack falls on the edge ending the first Start=1 cycle in DONE.
- Reset asserted mid-RUN takes effect on the next edge regardless of Start, Halt or Stall.

## Test plan
- Reset, Start pulse of 2 cycles, 5 sequential cycles then Halt -> PgmCtr 0,1,2,3,4,5 held; Ack=1; InstCt=6; CycleCt=6.
- PW=4, straight run from 0 for 17 cycles -> PgmCtr wraps 15→0; Ack stays 0.
- At PC=8: absolute branch Target=3 -> PC=3. Then a relative branch with Target=-2 (all-ones minus 1) -> PC=1. Then at PC=0, relative branch Target=-1 -> PC=2**PW-1.
- Stall held 3 cycles at PC=5 with BranchEn=1 also high -> PC stays 5; CycleCt+3; InstCt+0; PC advances after Stall drops.
- Halt and Stall together at PC=7 -> DONE, Ack=1, PC=7. Start reasserted during RUN -> ARM, PC=0, counters 0, Ack=0.
- CW=4, 20 RUN cycles -> CycleCt=15 saturated. Reset asserted in the same cycle as Halt -> IDLE, Ack=0.
